// File: rtl/sgpio_act_rx_pkg.sv
// Shared definitions for the SGPIO activity receiver: default sizing,
// receiver state encodings and a small width helper.
package sgpio_act_rx_pkg;

  localparam int SGPIO_NUM_DRV     = 36;
  localparam int SGPIO_TIMEOUT_CYC = 250000;
  localparam int SGPIO_ERR_W       = 8;

  typedef enum logic [1:0] {
    SGPIO_RX_IDLE  = 2'd0,
    SGPIO_RX_SHIFT = 2'd1,
    SGPIO_RX_LOST  = 2'd2
  } rx_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sgpio_sync_edge.sv
// Three-flop synchroniser for asynchronous link pins. All lanes share the
// same depth so they stay mutually aligned; lane 0 also gets a rising-edge
// detect taken between the second and third stage.
module sgpio_sync_edge #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic             rise_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [WIDTH-1:0] s3_q;

  // Two metastability stages followed by one edge-detect delay stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign sync_o = s3_q;
  assign rise_o = s2_q[0] & ~s3_q[0];

endmodule

// File: rtl/sgpio_act_rx.sv
// SGPIO activity receiver: oversamples SGPIO_CK/LD/DATA in the SYSCLK
// domain, deserialises one frame per LD period and publishes it on ACT_LED.
// Malformed frame lengths are flagged and counted; a silent link clock
// drops the receiver into LOST and blanks the LEDs.
// Optional build macro SGPIO_FRAME_MATCH_EN: a frame is only committed when
// it equals the previous well-formed frame (debounce against bit errors).
module sgpio_act_rx
  import sgpio_act_rx_pkg::*;
#(
  parameter int NUM_DRV     = SGPIO_NUM_DRV,
  parameter int TIMEOUT_CYC = SGPIO_TIMEOUT_CYC,
  parameter int ERR_W       = SGPIO_ERR_W
) (
  input  logic               SYSCLK,
  input  logic               RESET_N,
  input  logic               SGPIO_CK,
  input  logic               SGPIO_LD,
  input  logic               SGPIO_DATA,
  output logic [NUM_DRV-1:0] ACT_LED,
  output logic               FRAME_VALID,
  output logic               FRAME_ERR,
  output logic               LINK_OK,
  output logic [ERR_W-1:0]   ERR_CNT
);

  // bit_cnt must reach NUM_DRV+1, the sticky overrun marker.
  localparam int CNT_W = $clog2(NUM_DRV + 2);
  localparam int TO_W  = cnt_width(TIMEOUT_CYC);

  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(NUM_DRV);
  localparam logic [CNT_W-1:0] CNT_OVERRUN = CNT_W'(NUM_DRV + 1);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYC - 1);

  logic [2:0] sync_w;
  logic       ck_rise;
  logic       ld_s;
  logic       data_s;
  logic       unused_ck_s3;

  sgpio_sync_edge #(
    .WIDTH(3)
  ) u_sync (
    .clk_i  (SYSCLK),
    .rst_ni (RESET_N),
    .async_i({SGPIO_DATA, SGPIO_LD, SGPIO_CK}),
    .sync_o (sync_w),
    .rise_o (ck_rise)
  );

  assign data_s       = sync_w[2];
  assign ld_s         = sync_w[1];
  assign unused_ck_s3 = sync_w[0];

  rx_state_e          state_q,   state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NUM_DRV-1:0] shift_q,   shift_d;
  logic [TO_W-1:0]    to_cnt_q,  to_cnt_d;
  logic [NUM_DRV-1:0] act_q,     act_d;
  logic               fv_q,      fv_d;
  logic               fe_q,      fe_d;
  logic               link_q,    link_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
`ifdef SGPIO_FRAME_MATCH_EN
  logic [NUM_DRV-1:0] shadow_q,  shadow_d;
`endif

  // State and output registers; reset returns everything to a blank link.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= SGPIO_RX_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      to_cnt_q  <= '0;
      act_q     <= '0;
      fv_q      <= 1'b0;
      fe_q      <= 1'b0;
      link_q    <= 1'b0;
      err_cnt_q <= '0;
`ifdef SGPIO_FRAME_MATCH_EN
      shadow_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      to_cnt_q  <= to_cnt_d;
      act_q     <= act_d;
      fv_q      <= fv_d;
      fe_q      <= fe_d;
      link_q    <= link_d;
      err_cnt_q <= err_cnt_d;
`ifdef SGPIO_FRAME_MATCH_EN
      shadow_q  <= shadow_d;
`endif
    end
  end

  // Frame FSM: act on each link clock rise, otherwise run the loss timer.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    act_d     = act_q;
    fv_d      = 1'b0;
    fe_d      = 1'b0;
    link_d    = link_q;
    err_cnt_d = err_cnt_q;
`ifdef SGPIO_FRAME_MATCH_EN
    shadow_d  = shadow_q;
`endif
    to_cnt_d  = (to_cnt_q == TO_LAST) ? to_cnt_q : to_cnt_q + TO_W'(1);

    if (ck_rise) begin
      // A live clock edge always wins over an expiring timer.
      to_cnt_d = '0;
      if (ld_s) begin
        if (state_q == SGPIO_RX_SHIFT) begin
          if (bit_cnt_q == CNT_FULL) begin
`ifdef SGPIO_FRAME_MATCH_EN
            shadow_d = shift_q;
            if (shift_q == shadow_q) begin
              act_d  = shift_q;
              fv_d   = 1'b1;
              link_d = 1'b1;
            end
`else
            act_d  = shift_q;
            fv_d   = 1'b1;
            link_d = 1'b1;
`endif
          end else begin
            fe_d = 1'b1;
            if (err_cnt_q != {ERR_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
          end
        end
        // Every LD opens a new capture with bit 0 already taken.
        shift_d    = '0;
        shift_d[0] = data_s;
        bit_cnt_d  = CNT_W'(1);
        state_d    = SGPIO_RX_SHIFT;
      end else if (state_q == SGPIO_RX_SHIFT) begin
        if (bit_cnt_q < CNT_FULL) begin
          for (int i = 0; i < NUM_DRV; i++) begin
            if (bit_cnt_q == CNT_W'(i)) begin
              shift_d[i] = data_s;
            end
          end
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end else begin
          // Too many bits: park on the overrun marker so the next LD errors.
          bit_cnt_d = CNT_OVERRUN;
        end
      end
    end else if (to_cnt_q == TO_LAST) begin
      state_d   = SGPIO_RX_LOST;
      link_d    = 1'b0;
      act_d     = '0;
      bit_cnt_d = '0;
`ifdef SGPIO_FRAME_MATCH_EN
      shadow_d  = '0;
`endif
    end
  end

  assign ACT_LED     = act_q;
  assign FRAME_VALID = fv_q;
  assign FRAME_ERR   = fe_q;
  assign LINK_OK     = link_q;
  assign ERR_CNT     = err_cnt_q;

endmodule
